// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply-divide unit for the MIPS core.
// Uses one add/subtract per cycle: MULT/MULTU/DIV/DIVU take 33 edges, and MTHI/MTLO take one.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  opb_q, opb_d;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]  sh_q, sh_d;        // multiplier/product-low or dividend/quotient
  logic [WIDTH-1:0]  acc_q, acc_d;      // product-high or partial remainder
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_div_q, is_div_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH-1:0]  div_sub;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    state_d   = state_q;
    count_d   = count_q;
    opb_d     = opb_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // MULT and DIV have op[0]=0. The magnitude of the most negative value wraps to the correct unsigned value.
    signed_op = ~op[0];
    abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[WIDTH-1:0] - opb_q;
    product   = {acc_q, sh_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              sh_d      = abs_a;
              opb_d     = abs_b;
              acc_d     = '0;
              count_d   = '0;
              busy_d    = 1'b1;
              is_div_d  = op[1];
              // A zero divisor must leave the all-ones quotient un-negated.
              neg_quo_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && !(op[1] && b == '0);
              neg_rem_d = signed_op && a[WIDTH-1];
              state_d   = op[1] ? DIV : MUL;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (state_q == MUL) begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end else if (div_ge) begin
          acc_d = div_sub;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_quo_q ? -sh_q  : sh_q;
          hi_d = neg_rem_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_quo_q ? -product : product;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      opb_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      count_q   <= count_d;
      opb_q     <= opb_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written corner sequences,
// and random MULT/DIV operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: returns {hi, lo}, computed with ordinary 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return ux * uy;
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = longint'(ux / uy);
        r = longint'(ux % uy);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Issue one MULT/DIV and follow it to completion. With mthi_spam set, MTHI is requested
  // on every busy cycle; those requests must all be ignored.
  task automatic run_muldiv(input string tag, input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                            input bit mthi_spam);
    int          edges;
    bit          hold_bad, busy_bad;
    logic [31:0] h0, l0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    if (mthi_spam) begin
      op = 3'b100; a = 32'hBAD0_BAD0;
    end else begin
      start = 1'b0; a = $urandom; b = $urandom;
    end
    check({tag, " busy@E0"}, 64'(busy), 64'd1);
    h0 = hi; l0 = lo;
    edges = 0; hold_bad = 0; busy_bad = 0;
    while (!done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (!done && (hi !== h0 || lo !== l0)) hold_bad = 1;
      if (!done && !busy) busy_bad = 1;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " hi/lo"}, {hi, lo}, {eh, el});
    check({tag, " hold+busy"}, {62'd0, hold_bad, busy_bad}, 64'd0);
    check({tag, " busy@done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [63:0] exp;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          seen;

    vecs.push_back('{"multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"mult_neg",   3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mult_min2",  3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu_small", 3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003});
    vecs.push_back('{"divu_big",   3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC});
    vecs.push_back('{"div_zero",   3'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF});
    vecs.push_back('{"div_wrap",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"div_negz",   3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    check("reset state", {30'd0, busy, done, hi[15:0], lo[15:0]}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (vecs[i])
      run_muldiv(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);

    // MTLO and MTHI in IDLE: written on the next edge, with no busy and no done.
    @(negedge clk); op = 3'b101; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("mtlo lo", 64'(lo), 64'hDEAD_BEEF);
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);
    @(negedge clk); op = 3'b100; a = 32'hCAFE_F00D; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("mthi hi/lo", {hi, lo}, {32'hCAFE_F00D, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);

    // op=11x is a no-op.
    @(negedge clk); op = 3'b110; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    @(posedge clk); #1; op = 3'b111;
    @(posedge clk); #1; start = 1'b0;
    check("nop hi/lo", {hi, lo}, {32'hCAFE_F00D, 32'hDEAD_BEEF});
    check("nop busy", 64'(busy), 64'd0);

    // MTHI requested throughout a busy MULTU: hi must carry only the product.
    run_muldiv("mthi_busy", 3'd1, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b1);

    // Back-to-back random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(3, 0));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7, 0) == 0) rb = '0;
      if ($urandom_range(7, 0) == 0) ra = 32'h8000_0000;
      if ($urandom_range(7, 0) == 0) rb = 32'hFFFF_FFFF;
      if ($urandom_range(3, 0) == 0) rb = rb & 32'h0000_00FF;
      exp = model(ro, ra, rb);
      run_muldiv($sformatf("rand%0d", i), ro, ra, rb, exp[63:32], exp[31:0], 1'b0);
    end

    // Asynchronous reset at E10 of a DIVU aborts it immediately.
    @(negedge clk); op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort busy/done", {62'd0, busy, done}, 64'd0);
    check("abort hi/lo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);
    run_muldiv("post_reset", 3'd1, 32'd3, 32'd5, 32'd0, 32'h0000_000F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
